riscv_ex_mc: RTL and testbench

RISCV_EX_MC -- requirements
Module: riscv_ex_mc

---
 rtl/riscv_ex_mc.sv | 150 +++++++++++++++
 tb/tb_riscv_ex_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_mc.sv
// rtl/riscv_ex_mc.sv - RISC-V execute stage: single-cycle ALU plus iterative shift-add multiplier
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready low while a multiply runs)
//   rdi                  destination register tag
//   a, b, shamt          operands and shift amount
//   funct3               RISC-V funct3 op select
//   invertb              SUB instead of ADD, SRA instead of SRL
//   mext                 multiply group (funct3=011 MULHU, otherwise MUL)
//   load                 load address computation flag, returned as memfetch
//   result, rd, memfetch registered outputs, qualified by out_valid (one cycle)
module riscv_ex_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rdi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  input  logic [2:0]      funct3,
  input  logic            invertb,
  input  logic            mext,
  input  logic            load,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            memfetch,
  output logic            out_valid
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [SHW-1:0]      r_cnt;
  logic [2*XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_mplier;
  logic [4:0]          r_mul_rd;
  logic                r_mul_load;
  logic                r_mul_hi;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd;
  logic                r_memfetch;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_mul_done;
  logic                w_slt;
  logic                w_sltu;
  logic signed [XLEN-1:0] w_sra;
  logic [XLEN-1:0]     w_alu;
  logic [2*XLEN-1:0]   w_prod_next;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign result    = r_result;
  assign rd        = r_rd;
  assign memfetch  = r_memfetch;
  assign out_valid = r_out_valid;

  // Arithmetic shift kept in its own signed net so the surrounding
  // unsigned mux cannot turn it into a logical shift.
  assign w_sra  = $signed(a) >>> shamt;
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  // One partial-product step: add the shifted multiplicand when the
  // current multiplier LSB is set.
  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  // Counter holds the number of completed iterations; this edge is the last.
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == SHW'(XLEN - 1));

  always_comb begin
    w_alu = '0;
    case (funct3)
      3'b000:  w_alu = invertb ? (a - b) : (a + b);
      3'b001:  w_alu = a << shamt;
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_sltu};
      3'b100:  w_alu = a ^ b;
      3'b101:  w_alu = invertb ? w_sra : (a >> shamt);
      3'b110:  w_alu = a | b;
      default: w_alu = a & b;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && mext) w_state_next = S_MUL;
      S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_mul_rd    <= '0;
      r_mul_load  <= 1'b0;
      r_mul_hi    <= 1'b0;
      r_result    <= '0;
      r_rd        <= '0;
      r_memfetch  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (mext) begin
            r_mcand    <= {{XLEN{1'b0}}, a};
            r_mplier   <= b;
            r_prod     <= '0;
            r_cnt      <= '0;
            r_mul_rd   <= rdi;
            r_mul_load <= load;
            r_mul_hi   <= (funct3 == 3'b011);
          end else begin
            r_result    <= w_alu;
            r_rd        <= rdi;
            r_memfetch  <= load;
            r_out_valid <= 1'b1;
          end
        end
      end else begin
        r_prod   <= w_prod_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SHW'(1);
        if (w_mul_done) begin
          r_result    <= r_mul_hi ? w_prod_next[2*XLEN-1:XLEN] : w_prod_next[XLEN-1:0];
          r_rd        <= r_mul_rd;
          r_memfetch  <= r_mul_load;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_mc.sv
// tb/tb_riscv_ex_mc.sv - self-checking bench for riscv_ex_mc (XLEN=32 modelled, XLEN=8 directed)
module tb_riscv_ex_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rdi = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic [2:0]  funct3 = '0;
  logic        invertb = 1'b0;
  logic        mext = 1'b0;
  logic        load = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd;
  logic        memfetch;
  logic        out_valid;

  logic        e_in_valid = 1'b0;
  logic        e_in_ready;
  logic [4:0]  e_rdi = '0;
  logic [7:0]  e_a = '0;
  logic [7:0]  e_b = '0;
  logic [2:0]  e_shamt = '0;
  logic [2:0]  e_funct3 = '0;
  logic        e_invertb = 1'b0;
  logic        e_mext = 1'b0;
  logic        e_load = 1'b0;
  logic [7:0]  e_result;
  logic [4:0]  e_rd;
  logic        e_memfetch;
  logic        e_out_valid;

  riscv_ex_mc #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rdi(rdi), .a(a), .b(b), .shamt(shamt), .funct3(funct3),
    .invertb(invertb), .mext(mext), .load(load),
    .result(result), .rd(rd), .memfetch(memfetch), .out_valid(out_valid)
  );

  riscv_ex_mc #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .rdi(e_rdi), .a(e_a), .b(e_b), .shamt(e_shamt), .funct3(e_funct3),
    .invertb(e_invertb), .mext(e_mext), .load(e_load),
    .result(e_result), .rd(e_rd), .memfetch(e_memfetch), .out_valid(e_out_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] sh, input logic [2:0] f,
                                          input logic inv);
    logic signed [31:0] sx;
    sx = x;
    case (f)
      3'd0: return inv ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return inv ? 32'(sx >>> sh) : x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] f);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    return (f == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  // Model: busy_left counts the multiply cycles still to run.
  int          busy_left = 0;
  logic        m_ov = 1'b0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;
  logic        m_mf = 1'b0;
  logic [31:0] p_res;
  logic [4:0]  p_rd;
  logic        p_mf;

  always @(posedge clk) begin
    if (rst) begin
      busy_left = 0; m_ov = 1'b0; m_res = '0; m_rd = '0; m_mf = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      m_ov = 1'b0;
      if (busy_left == 0) begin
        m_ov = 1'b1; m_res = p_res; m_rd = p_rd; m_mf = p_mf;
      end
    end else begin
      m_ov = 1'b0;
      if (in_valid) begin
        if (mext) begin
          busy_left = 32;
          p_res = ref_mul(a, b, funct3); p_rd = rdi; p_mf = load;
        end else begin
          m_ov = 1'b1; m_res = ref_alu(a, b, shamt, funct3, invertb); m_rd = rdi; m_mf = load;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("in_ready", 64'(in_ready), 64'(busy_left == 0));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        check("result", 64'(result), 64'(m_res));
        check("rd", 64'(rd), 64'(m_rd));
        check("memfetch", 64'(memfetch), 64'(m_mf));
      end
    end
  end

  task automatic issue(input logic [4:0] r, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, input logic [2:0] f, input logic inv,
                       input logic mx, input logic ld);
    rdi = r; a = x; b = y; shamt = sh; funct3 = f; invertb = inv; mext = mx; load = ld;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [2:0] f,
                        input logic mx);
    e_rdi = 5'd3; e_a = x; e_b = y; e_funct3 = f; e_mext = mx; e_invertb = 1'b0;
    e_in_valid = 1'b1;
    @(negedge clk);
    e_in_valid = 1'b0;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("reset_result", 64'(result), 64'd0);
    check("reset_rd", 64'(rd), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    issue(5'd4, 32'd40, 32'd2, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("add_result", 64'(result), 64'd42);
    check("add_rd", 64'(rd), 64'd4);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_memfetch", 64'(memfetch), 64'd0);

    issue(5'd1, 32'd40, 32'd5, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    check("sub_result", 64'(result), 64'd35);
    check("sub_memfetch", 64'(memfetch), 64'd1);
    issue(5'd2, 32'h8000_0000, 32'd0, 5'd4, 3'd5, 1'b1, 1'b0, 1'b0);
    check("sra_result", 64'(result), 64'hF800_0000);
    check("sra_valid", 64'(out_valid), 64'd1);

    // All funct3, both invertb values, shamt 0/31, zero operands.
    for (int i = 0; i < 32; i++) begin
      issue(5'(i), (i < 8) ? 32'd0 : $urandom, (i % 5 == 0) ? 32'd0 : $urandom,
            (i < 16) ? 5'd0 : ((i < 24) ? 5'd31 : 5'($urandom)), 3'(i), i[3], 1'b0, i[4]);
    end
    issue(5'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    check("slt_neg", 64'(result), 64'd1);

    issue(5'd9, 32'hFFFF_FFFF, 32'd2, 5'd0, 3'd3, 1'b0, 1'b1, 1'b0);
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("mulhu_latency", 64'(n), 64'd33);
    check("mulhu_result", 64'(result), 64'd1);
    check("mulhu_rd", 64'(rd), 64'd9);
    issue(5'd9, 32'hFFFF_FFFF, 32'd2, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("mul_latency", 64'(n), 64'd33);
    check("mul_result", 64'(result), 64'hFFFF_FFFE);

    // ADD held on in_valid while multiplier is busy.
    issue(5'd7, 32'd3, 32'd5, 5'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    rdi = 5'd12; a = 32'd1; b = 32'd2; funct3 = 3'd0; mext = 1'b0; load = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    check("busy_wait", 64'(n), 64'd32);
    check("busy_mul_result", 64'(result), 64'd15);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_add_result", 64'(result), 64'd3);
    check("held_add_rd", 64'(rd), 64'd12);

    // Random multiplies including zero operand.
    issue(5'd13, 32'd0, $urandom, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    repeat (34) @(negedge clk);
    issue(5'd14, $urandom, $urandom, 5'd0, 3'd3, 1'b0, 1'b1, 1'b0);
    repeat (34) @(negedge clk);

    // Reset mid-multiply, with in_valid presented during the reset edge.
    issue(5'd15, 32'd7, 32'd9, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    issue(5'd16, 32'd1, 32'd1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_result", 64'(result), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);

    // XLEN=8 instance.
    issue8(8'hF0, 8'h20, 3'd0, 1'b0);
    check("x8_add", 64'(e_result), 64'h10);
    check("x8_add_valid", 64'(e_out_valid), 64'd1);
    issue8(8'h10, 8'h10, 3'd0, 1'b1);
    n = 1;
    while (!e_out_valid && n < 20) begin @(negedge clk); n++; end
    check("x8_mul_latency", 64'(n), 64'd9);
    check("x8_mul", 64'(e_result), 64'h00);
    issue8(8'h10, 8'h10, 3'd3, 1'b1);
    n = 1;
    while (!e_out_valid && n < 20) begin @(negedge clk); n++; end
    check("x8_mulhu_latency", 64'(n), 64'd9);
    check("x8_mulhu", 64'(e_result), 64'h01);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
